cipher_pattern_filter: RTL



---
 rtl/cipher_filter_pkg.sv | 26 ++
 rtl/cipher_pattern_filter_if.sv | 31 +++
 rtl/cipher_pattern_filter_pulse_stretcher.sv | 35 +++
 rtl/cipher_pattern_filter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cipher_filter_pkg.sv
`default_nettype none
// ============================================================
// Package : cipher_filter_pkg
// Brief   : shared types, default constants and byte-select helper
// Rev     : 1.0 - initial release
// ============================================================
package cipher_filter_pkg;

    localparam int MAX_BITS = 256;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MATCH = 1'b1
    } match_state_t;

    localparam logic [31:0] DEFAULT_KEY     = 32'hDEADBEEF;
    localparam logic [23:0] DEFAULT_PATTERN = 24'h434154;

    // Byte idx of a len-byte vector, byte 0 being the most significant.
    function automatic logic [7:0] get_byte(input logic [MAX_BITS-1:0] vec,
                                            input int idx, input int len);
        return vec[(len-1-idx)*8 +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cipher_pattern_filter_if.sv
`default_nettype none
// ============================================================
// Interface : cipher_pattern_filter_if
// Brief     : byte stream in, decrypted stream and verdicts out
// Rev       : 1.0 - initial release
// ============================================================
interface cipher_pattern_filter_if #(
    parameter int COUNT_W = 8
);
    logic [7:0]         data_in;
    logic               data_valid;
    logic               resync;
    logic [7:0]         dec_data;
    logic               dec_valid;
    logic               accept;
    logic               reject;
    logic               accept_led;
    logic               reject_led;
    logic [COUNT_W-1:0] accept_count;

    modport master (
        output data_in, data_valid, resync,
        input  dec_data, dec_valid, accept, reject, accept_led, reject_led, accept_count
    );

    modport slave (
        input  data_in, data_valid, resync,
        output dec_data, dec_valid, accept, reject, accept_led, reject_led, accept_count
    );
endinterface
`default_nettype wire

// File: rtl/cipher_pattern_filter_pulse_stretcher.sv
`default_nettype none
// ============================================================
// Module : pulse_stretcher
// Brief  : holds led high for CYCLES clocks after trig; clear cancels
// Rev    : 1.0 - initial release
// ============================================================
module pulse_stretcher #(
    parameter int CYCLES = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    input  logic clear,
    output logic led
);
    localparam int                 c_cnt_w = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_load  = c_cnt_w'(CYCLES);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (trig) begin
            r_cnt <= c_load;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    assign led = (r_cnt != '0);
endmodule
`default_nettype wire

// File: rtl/cipher_pattern_filter.sv
`default_nettype none
// ============================================================
// Module : cipher_pattern_filter
// Brief  : repeating-XOR decrypt, pattern matcher, timeout, LED stretch
// Rev    : 1.0 - initial release
// ============================================================
module cipher_pattern_filter
    import cipher_filter_pkg::*;
#(
    parameter int                   KEY_LEN        = 4,
    parameter logic [KEY_LEN*8-1:0] KEY            = DEFAULT_KEY,
    parameter int                   PAT_LEN        = 3,
    parameter logic [PAT_LEN*8-1:0] PATTERN        = DEFAULT_PATTERN,
    parameter int                   TIMEOUT_CYCLES = 1200,
    parameter int                   STRETCH_CYCLES = 1200000,
    parameter int                   COUNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    cipher_pattern_filter_if.slave  bus
);
    localparam int c_kidx_w = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int c_pos_w  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int c_idle_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT_CYCLES);
    localparam logic [MAX_BITS-1:0] c_key_ext  = MAX_BITS'(KEY);
    localparam logic [MAX_BITS-1:0] c_pat_ext  = MAX_BITS'(PATTERN);

    logic [c_kidx_w-1:0] r_key_idx;
    logic [c_idle_w-1:0] r_idle;
    logic [7:0]          r_dec_data;
    logic                r_dec_valid;
    match_state_t        r_state;
    logic [c_pos_w-1:0]  r_pos;
    logic                r_accept;
    logic                r_reject;
    logic [COUNT_W-1:0]  r_count;
    logic                w_take;
    logic                w_timeout;

    // resync beats a coincident strobe, so the byte never enters the pipe
    assign w_take    = bus.data_valid && !bus.resync;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !bus.data_valid && !bus.resync &&
                       (int'(r_idle) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_idx   <= '0;
            r_idle      <= '0;
            r_dec_data  <= '0;
            r_dec_valid <= 1'b0;
        end else begin
            r_dec_valid <= w_take;
            if (w_take) begin
                r_dec_data <= bus.data_in ^ get_byte(c_key_ext, int'(r_key_idx), KEY_LEN);
            end

            if (bus.resync || w_timeout) begin
                r_key_idx <= '0;
            end else if (bus.data_valid) begin
                r_key_idx <= (int'(r_key_idx) == KEY_LEN - 1) ? '0 : r_key_idx + c_kidx_w'(1);
            end

            if (bus.resync || bus.data_valid) begin
                r_idle <= '0;
            end else if (r_idle != c_idle_max) begin
                r_idle <= r_idle + c_idle_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pos    <= '0;
            r_accept <= 1'b0;
            r_reject <= 1'b0;
            r_count  <= '0;
        end else begin
            r_accept <= 1'b0;
            r_reject <= 1'b0;
            if (bus.resync) begin
                r_state <= IDLE;
                r_pos   <= '0;
            end else if (r_dec_valid) begin
                if (r_dec_data == get_byte(c_pat_ext, int'(r_pos), PAT_LEN)) begin
                    if (int'(r_pos) + 1 < PAT_LEN) begin
                        r_pos   <= r_pos + c_pos_w'(1);
                        r_state <= MATCH;
                    end else begin
                        r_accept <= 1'b1;
                        r_pos    <= '0;
                        r_state  <= IDLE;
                        if (r_count != '1) begin
                            r_count <= r_count + COUNT_W'(1);
                        end
                    end
                end else if (r_state == MATCH) begin
                    // Only the first pattern byte is tried as a restart point
                    r_reject <= 1'b1;
                    if (r_dec_data == get_byte(c_pat_ext, 0, PAT_LEN)) begin
                        r_pos   <= c_pos_w'(1);
                        r_state <= MATCH;
                    end else begin
                        r_pos   <= '0;
                        r_state <= IDLE;
                    end
                end
            end else if (w_timeout && (r_pos != '0)) begin
                r_reject <= 1'b1;
                r_pos    <= '0;
                r_state  <= IDLE;
            end
        end
    end

    pulse_stretcher #(.CYCLES(STRETCH_CYCLES)) u_accept_led (
        .clk   (clk),
        .rst   (rst),
        .trig  (r_accept),
        .clear (r_reject),
        .led   (bus.accept_led)
    );

    pulse_stretcher #(.CYCLES(STRETCH_CYCLES)) u_reject_led (
        .clk   (clk),
        .rst   (rst),
        .trig  (r_reject),
        .clear (r_accept),
        .led   (bus.reject_led)
    );

    assign bus.dec_data     = r_dec_data;
    assign bus.dec_valid    = r_dec_valid;
    assign bus.accept       = r_accept;
    assign bus.reject       = r_reject;
    assign bus.accept_count = r_count;
endmodule
`default_nettype wire
